// File: rtl/trace_capture_fifo.sv
// Trace capture buffer: queues kept retired instructions with their skip count and an
// overflow marker, and presents them first-word-fall-through on a valid/ready stream.
module trace_capture_fifo #(
   parameter int PC_WIDTH        = 64,
   parameter int INSTR_WIDTH     = 32,
   parameter int DEPTH           = 16,
   parameter int SKIP_CNT_WIDTH  = 16,
   parameter int ALMOST_FULL_LVL = 12
) (
   input  logic                                             clk,
   input  logic                                             rst,
   input  logic                                             enable,
   input  logic                                             pc_valid,
   input  logic [PC_WIDTH-1:0]                              pc,
   input  logic [INSTR_WIDTH-1:0]                           instr,
   input  logic                                             drop_instr,
   output logic                                             m_valid,
   input  logic                                             m_ready,
   output logic [SKIP_CNT_WIDTH+INSTR_WIDTH+PC_WIDTH:0]     m_data,
   output logic [$clog2(DEPTH):0]                           count,
   output logic                                             almost_full,
   output logic [SKIP_CNT_WIDTH-1:0]                        lost_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 1 + SKIP_CNT_WIDTH + INSTR_WIDTH + PC_WIDTH;
   localparam logic [SKIP_CNT_WIDTH-1:0] SAT_MAX = '1;

   logic [EW-1:0]             mem [DEPTH];
   logic [AW-1:0]             wr_ptr;
   logic [AW-1:0]             rd_ptr;
   logic [SKIP_CNT_WIDTH-1:0] skip_cnt;
   logic                      ovf_pending;
   logic                      full;
   logic                      drop;
   logic                      keep;
   logic                      push;
   logic                      lost;
   logic                      pop;
   logic [CW-1:0]             count_nxt;

   function automatic logic [SKIP_CNT_WIDTH-1:0] sat_inc(input logic [SKIP_CNT_WIDTH-1:0] v);
      return (v == SAT_MAX) ? v : v + 1'b1;
   endfunction

   // full comes from the registered count only, so a same-cycle pop never makes room
   assign full    = (count == CW'(DEPTH));
   assign drop    = enable && pc_valid && drop_instr;
   assign keep    = enable && pc_valid && !drop_instr;
   assign push    = keep && !full;
   assign lost    = keep && full;
   assign m_valid = (count != '0);
   assign pop     = m_valid && m_ready;
   assign m_data  = m_valid ? mem[rd_ptr] : '0;

   always_comb begin
      count_nxt = count;
      if (push && !pop)
         count_nxt = count + 1'b1;
      else if (!push && pop)
         count_nxt = count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {ovf_pending, skip_cnt, instr, pc};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         almost_full <= 1'b0;
         skip_cnt    <= '0;
         ovf_pending <= 1'b0;
         lost_count  <= '0;
      end else begin
         count       <= count_nxt;
         almost_full <= (count_nxt >= CW'(ALMOST_FULL_LVL));
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (drop) begin
            skip_cnt <= sat_inc(skip_cnt);
         end else if (push) begin
            skip_cnt    <= '0;
            ovf_pending <= 1'b0;
         end else if (lost) begin
            // a lost instruction is reported downstream as a skipped one
            skip_cnt    <= sat_inc(skip_cnt);
            ovf_pending <= 1'b1;
            lost_count  <= sat_inc(lost_count);
         end
      end
   end

endmodule

// File: tb/tb_trace_capture_fifo.sv
// Bench for trace_capture_fifo: directed stimulus queues expected entries, a negedge
// monitor pops and compares on every accepted handshake.
module tb_trace_capture_fifo;

   localparam int EW = 113;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          pc_valid;
   logic [63:0]   pc;
   logic [31:0]   instr;
   logic          drop_instr;
   logic          m_valid;
   logic          m_ready;
   logic [EW-1:0] m_data;
   logic [4:0]    count;
   logic          almost_full;
   logic [15:0]   lost_count;

   int n_vec = 0;
   int n_err = 0;
   logic [EW-1:0] sb [$];

   trace_capture_fifo dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .pc_valid    (pc_valid),
      .pc          (pc),
      .instr       (instr),
      .drop_instr  (drop_instr),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .count       (count),
      .almost_full (almost_full),
      .lost_count  (lost_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1500000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   function automatic logic [EW-1:0] ent(input logic ovf, input logic [15:0] skip,
                                         input logic [31:0] ins, input logic [63:0] p);
      return {ovf, skip, ins, p};
   endfunction

   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_pop: got %h, required no entry", m_data);
         end else begin
            check("stream_data", {15'd0, m_data}, {15'd0, sb[0]});
            void'(sb.pop_front());
         end
      end
   end

   task automatic issue(input logic [63:0] p, input logic [31:0] ins, input logic drop);
      pc_valid   = 1'b1;
      pc         = p;
      instr      = ins;
      drop_instr = drop;
      @(posedge clk);
      #1;
      pc_valid   = 1'b0;
      drop_instr = 1'b0;
   endtask

   task automatic keep(input logic [63:0] p, input logic [31:0] ins, input logic [15:0] skip,
                       input logic ovf, input bit stored);
      if (stored)
         sb.push_back(ent(ovf, skip, ins, p));
      issue(p, ins, 1'b0);
   endtask

   task automatic drain(input int limit);
      for (int c = 0; c < limit && sb.size() != 0; c++) begin
         @(negedge clk);
         #1;
      end
      check("sb_drained", 128'(sb.size()), 128'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("count_after_drain", 128'(count), 128'd0);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; pc_valid = 1'b0; pc = '0; instr = '0;
      drop_instr = 1'b0; m_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_count", 128'(count), 128'd0);
      check("rst_m_valid", 128'(m_valid), 128'd0);
      check("rst_m_data", 128'(m_data), 128'd0);
      check("rst_almost_full", 128'(almost_full), 128'd0);
      check("rst_lost_count", 128'(lost_count), 128'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 1: three kept instructions, each visible one cycle after its write
      m_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         keep(64'h1000 + 64'(4 * k), 32'h13 + 32'(k), 16'd0, 1'b0, 1'b1);
         @(negedge clk);
         check("t1_latency_m_valid", 128'(m_valid), 128'd1);
      end
      drain(10);

      // 2: kept, five dropped, kept -> skip 0 then 5
      keep(64'h2000, 32'hA0, 16'd0, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) issue(64'h2004 + 64'(4 * k), 32'hB0, 1'b1);
      keep(64'h2018, 32'hA1, 16'd5, 1'b0, 1'b1);
      drain(10);

      // 3: fill with consumer stalled, two entries lost, overflow tagged on the next keep
      m_ready = 1'b0;
      for (int k = 0; k < 18; k++) begin
         keep(64'h3000 + 64'(4 * k), 32'h300 + 32'(k), 16'd0, 1'b0, k < 16);
         @(negedge clk);
         if (k == 10) check("t3_af_at_11", 128'(almost_full), 128'd0);
         if (k == 11) check("t3_af_at_12", 128'(almost_full), 128'd1);
      end
      check("t3_count_full", 128'(count), 128'd16);
      check("t3_lost_count", 128'(lost_count), 128'd2);
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      drain(40);
      keep(64'h3100, 32'h3FF, 16'd2, 1'b1, 1'b1);
      drain(10);

      // 4: full FIFO, push and pop in the same cycle -> push lost
      m_ready = 1'b0;
      for (int k = 0; k < 16; k++) keep(64'h4000 + 64'(4 * k), 32'h400 + 32'(k), 16'd0, 1'b0, 1'b1);
      m_ready = 1'b1;
      keep(64'h40F0, 32'h4FF, 16'd0, 1'b0, 1'b0);
      m_ready = 1'b0;
      @(negedge clk);
      check("t4_count", 128'(count), 128'd15);
      check("t4_lost_count", 128'(lost_count), 128'd3);
      for (int k = 0; k < 4; k++) begin
         check("t4_hold_m_data", 128'(m_data), 128'(ent(1'b0, 16'd0, 32'h401, 64'h4004)));
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      drain(40);

      // 5: saturating skip (ovf still pending from the lost push above), then enable=0
      for (int k = 0; k < 65539; k++) issue(64'h5000, 32'h500, 1'b1);
      keep(64'h5004, 32'h501, 16'hFFFF, 1'b1, 1'b1);
      drain(10);
      enable = 1'b0;
      issue(64'h5100, 32'h510, 1'b0);
      issue(64'h5104, 32'h511, 1'b1);
      issue(64'h5108, 32'h512, 1'b1);
      @(negedge clk);
      check("t5_disabled_count", 128'(count), 128'd0);
      check("t5_disabled_m_valid", 128'(m_valid), 128'd0);
      check("t5_disabled_lost", 128'(lost_count), 128'd3);
      @(posedge clk);
      #1;
      enable = 1'b1;
      keep(64'h5200, 32'h520, 16'd0, 1'b0, 1'b1);
      drain(10);

      // 6: async reset mid-burst with seven entries and a pending skip count
      m_ready = 1'b0;
      for (int k = 0; k < 7; k++) keep(64'h6000 + 64'(4 * k), 32'h600 + 32'(k), 16'd0, 1'b0, 1'b1);
      issue(64'h601C, 32'h6F0, 1'b1);
      issue(64'h6020, 32'h6F1, 1'b1);
      @(negedge clk);
      check("t6_count_before_rst", 128'(count), 128'd7);
      @(posedge clk);
      #1;
      pc_valid = 1'b1; pc = 64'h6024; instr = 32'h6F2; drop_instr = 1'b0;
      #2;
      rst = 1'b1;
      sb.delete();
      #1;
      check("t6_rst_count", 128'(count), 128'd0);
      check("t6_rst_m_valid", 128'(m_valid), 128'd0);
      check("t6_rst_m_data", 128'(m_data), 128'd0);
      check("t6_rst_almost_full", 128'(almost_full), 128'd0);
      check("t6_rst_lost_count", 128'(lost_count), 128'd0);
      pc_valid = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b0;
      m_ready = 1'b1;
      keep(64'h7000, 32'h700, 16'd0, 1'b0, 1'b1);
      drain(10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
